mem_responder: RTL and testbench

- Unified instruction/data memory that answers the multicycle core's memory requests over a valid/ready request channel and a pulsed response channel.
- It replaces the zero-latency combinational memory model with a configurable-latency responder, so the control FSM can be exercised against wait states.
- It supports word, halfword and byte accesses, little-endian, with alignment checking.

---
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified instruction/data memory with a valid/ready request channel and a
// fixed-latency, single-cycle response pulse; little-endian byte/half/word access.
module mem_responder #(
  parameter int    DEPTH_WORDS = 64,
  parameter int    LATENCY     = 2,
  parameter string MEMFILE     = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   adr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            in_resp;
  logic            align_err;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shifted;
  logic [31:0]     rd_data;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lanes;
  logic            unused_adr_hi;

  // Upper address bits are intentionally dropped so accesses wrap.
  assign unused_adr_hi = ^req_adr[31:AW+2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      adr_q   <= req_adr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    accept    = req_ready && req_valid && reset;
    // An asserted reset suppresses the response so aborted transactions stay silent.
    in_resp   = (state_q == RESP) && reset;

    align_err = (size_q == 2'b11)
             || ((size_q == 2'b10) && (adr_q[1:0] != 2'b00))
             || ((size_q == 2'b01) && adr_q[0]);

    word_idx   = adr_q[AW+1:2];
    rd_word    = mem[word_idx];
    rd_shifted = rd_word >> {adr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   rd_data = {24'h0, rd_shifted[7:0]};
      2'b01:   rd_data = {16'h0, rd_shifted[15:0]};
      default: rd_data = rd_word;
    endcase

    case (size_q)
      2'b00:   byte_en = 4'b0001 << adr_q[1:0];
      2'b01:   byte_en = adr_q[1] ? 4'b1100 : 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    case (size_q)
      2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
      2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
      default: wdata_lanes = wdata_q;
    endcase

    rsp_valid = in_resp;
    rsp_err   = in_resp && align_err;
    rsp_rdata = (in_resp && !align_err && !we_q) ? rd_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (in_resp && we_q && !align_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with latencies 2, 1 and 5
// share one clock and reset; expected responses are queued when each request is driven.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [1:0]  reqSize   [3];
  logic [31:0] reqAdr    [3];
  logic [31:0] reqWdata  [3];
  logic        rspValid  [3];
  logic [31:0] rspRdata  [3];
  logic        rspErr    [3];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        expQ [$];
  logic [31:0] modelMem [3][64];
  int          checks;
  int          failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(64),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
      .MEMFILE("")
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (reqValid[g]),
      .req_ready (reqReady[g]),
      .req_we    (reqWe[g]),
      .req_size  (reqSize[g]),
      .req_adr   (reqAdr[g]),
      .req_wdata (reqWdata[g]),
      .rsp_valid (rspValid[g]),
      .rsp_rdata (rspRdata[g]),
      .rsp_err   (rspErr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: little-endian lanes, alignment errors leave memory untouched.
  task automatic modelAccess(input int d, input logic we, input logic [1:0] size,
                             input logic [31:0] adr, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err);
    logic [31:0] word;
    int          idx;
    err  = (size == 2'b11) || ((size == 2'b10) && (adr[1:0] != 2'b00)) || ((size == 2'b01) && adr[0]);
    idx  = int'(adr[7:2]);
    word = modelMem[d][idx];
    rd   = 32'h0;
    if (!err) begin
      if (we) begin
        case (size)
          2'b00:   word[8*adr[1:0] +: 8] = wdata[7:0];
          2'b01:   word[16*adr[1] +: 16] = wdata[15:0];
          default: word = wdata;
        endcase
        modelMem[d][idx] = word;
      end else begin
        case (size)
          2'b00:   rd = {24'h0, word[8*adr[1:0] +: 8]};
          2'b01:   rd = {16'h0, word[16*adr[1] +: 16]};
          default: rd = word;
        endcase
      end
    end
  endtask

  task automatic applyStimulus(input int d, input logic we, input logic [1:0] size,
                               input logic [31:0] adr, input logic [31:0] wdata,
                               output logic [31:0] gotData, output logic gotErr);
    logic [31:0] expD;
    logic        expE;
    rsp_t        exp;
    int          n;
    bit          found;
    bit          busyBad;
    @(negedge clk);
    checkOutput("readyBeforeReq", reqReady[d], 1'b1);
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqSize[d]  = size;
    reqAdr[d]   = adr;
    reqWdata[d] = wdata;
    modelAccess(d, we, size, adr, wdata, expD, expE);
    expQ.push_back('{rdata: expD, err: expE});
    @(posedge clk);
    #1;
    // Keep valid high with junk writes while busy; the responder must ignore them.
    reqWe[d]    = 1'b1;
    reqSize[d]  = 2'b10;
    reqAdr[d]   = {$urandom_range(0, 15), 2'b00};
    reqWdata[d] = $urandom;
    found   = 1'b0;
    busyBad = 1'b0;
    gotData = 32'h0;
    gotErr  = 1'b0;
    n       = 0;
    while (!found && n < 30) begin
      @(negedge clk);
      n++;
      if (rspValid[d]) begin
        found       = 1'b1;
        reqValid[d] = 1'b0;
      end else if (reqReady[d]) begin
        busyBad = 1'b1;
      end
    end
    if (!found) reqValid[d] = 1'b0;
    checkOutput("rspLatency", n, latOf(d));
    checkOutput("readyLowWhileBusy", busyBad, 1'b0);
    if (found) begin
      gotData = rspRdata[d];
      gotErr  = rspErr[d];
      if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", expQ.size(), 1);
      end else begin
        exp = expQ.pop_front();
        checkOutput("rspRdata", gotData, exp.rdata);
        checkOutput("rspErr", gotErr, exp.err);
      end
    end else begin
      void'(expQ.pop_front());
    end
    @(negedge clk);
    checkOutput("pulseOneCycle", rspValid[d], 1'b0);
    checkOutput("readyAfterRsp", reqReady[d], 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          pulses;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      reqValid[d] = 1'b0;
      reqWe[d]    = 1'b0;
      reqSize[d]  = 2'b00;
      reqAdr[d]   = 32'h0;
      reqWdata[d] = 32'h0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("resetReady", reqReady[d], 1'b1);
      checkOutput("resetRspValid", rspValid[d], 1'b0);
      checkOutput("resetRdata", rspRdata[d], 32'h0);
      checkOutput("resetErr", rspErr[d], 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idleNoRsp", rspValid[0], 1'b0);
    end

    for (int w = 0; w < 16; w++) applyStimulus(0, 1'b1, 2'b10, w * 4, $urandom, rd, er);

    applyStimulus(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er);
    applyStimulus(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er);
    checkOutput("wordRead10", rd, 32'hDEADBEEF);

    applyStimulus(0, 1'b1, 2'b10, 32'h20, 32'h11223344, rd, er);
    applyStimulus(0, 1'b0, 2'b00, 32'h22, 32'h0, rd, er);
    checkOutput("byteRead22", rd, 32'h00000022);
    applyStimulus(0, 1'b0, 2'b01, 32'h22, 32'h0, rd, er);
    checkOutput("halfRead22", rd, 32'h00001122);
    applyStimulus(0, 1'b1, 2'b00, 32'h21, 32'hFFFFFFAA, rd, er);
    applyStimulus(0, 1'b0, 2'b10, 32'h20, 32'h0, rd, er);
    checkOutput("wordAfterByteWr", rd, 32'h1122AA44);

    applyStimulus(0, 1'b1, 2'b10, 32'h13, 32'h55555555, rd, er);
    checkOutput("misWordWrErr", er, 1'b1);
    applyStimulus(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, er);
    checkOutput("unchangedAfterErr", rd, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 2'b01, 32'h11, 32'h0, rd, er);
    checkOutput("misHalfErr", er, 1'b1);
    applyStimulus(0, 1'b0, 2'b11, 32'h0, 32'h0, rd, er);
    checkOutput("reservedSizeErr", er, 1'b1);

    applyStimulus(0, 1'b1, 2'b10, 32'h104, 32'hCAFEF00D, rd, er);
    applyStimulus(0, 1'b0, 2'b10, 32'h04, 32'h0, rd, er);
    checkOutput("wrapRead04", rd, 32'hCAFEF00D);

    applyStimulus(1, 1'b1, 2'b10, 32'h10, 32'hA5A5_0001, rd, er);
    applyStimulus(1, 1'b0, 2'b10, 32'h10, 32'h0, rd, er);
    checkOutput("lat1Read", rd, 32'hA5A5_0001);
    applyStimulus(2, 1'b1, 2'b10, 32'h10, 32'h5A5A_0005, rd, er);
    applyStimulus(2, 1'b0, 2'b10, 32'h10, 32'h0, rd, er);
    checkOutput("lat5Read", rd, 32'h5A5A_0005);

    applyStimulus(0, 1'b1, 2'b10, 32'h30, 32'h0, rd, er);
    @(negedge clk);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;
    reqSize[0]  = 2'b10;
    reqAdr[0]   = 32'h30;
    reqWdata[0] = 32'h12345678;
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    reset       = 1'b0;
    pulses      = 0;
    @(negedge clk);
    if (rspValid[0]) pulses++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rspValid[0]) pulses++;
    end
    checkOutput("midResetPulses", pulses, 0);
    applyStimulus(0, 1'b0, 2'b10, 32'h30, 32'h0, rd, er);
    checkOutput("midResetNoCommit", rd, 32'h0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    {22'h0, 2'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 63))},
                    $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
